// File: rtl/sms_timing_pkg.sv
// Shared types and defaults for the machine-cycle timing ring.
// Carries the run-state enum, default geometry and the one-hot gate builder.
package sms_timing_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam int DEF_POSITIONS    = 10;
  localparam int DEF_PHASE_CYCLES = 4;
  localparam int DEF_PULSE_PHASE  = 2;
  localparam int MAX_POSITIONS    = 16;

  // Built at the widest legal ring size; callers keep the low POSITIONS bits.
  function automatic logic [MAX_POSITIONS-1:0] onehot_gate(input logic [3:0] pos);
    logic [MAX_POSITIONS-1:0] v;
    v      = '0;
    v[pos] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/sms_timing_phase_ctr.sv
// Phase counter for one ring position: counts 0..PHASE_CYCLES-1 and wraps.
// Latency: phase_nxt is combinational, phase registers on posedge x.
// Backpressure: none; under SMS_TIMING_RING_STEP_EN the count waits for a step rising edge.
module sms_timing_phase_ctr
  import sms_timing_pkg::*;
#(
  parameter int PHASE_CYCLES = DEF_PHASE_CYCLES
) (
  input  logic                              x,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              en,
`ifdef SMS_TIMING_RING_STEP_EN
  input  logic                              step_mode,
  input  logic                              step,
`endif
  output logic [$clog2(PHASE_CYCLES)-1:0]   phase_nxt,
  output logic                              tc,
  output logic                              adv
);

  localparam int              PH_W    = $clog2(PHASE_CYCLES);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASE_CYCLES - 1);

  logic [PH_W-1:0] phase;

`ifdef SMS_TIMING_RING_STEP_EN
  logic step_prev;

  always_ff @(posedge x) begin
    if (rst) step_prev <= 1'b0;
    else     step_prev <= step;
  end

  // In step mode only the clock where step first goes high counts.
  assign adv = en && (!step_mode || (step && !step_prev));
`else
  assign adv = en;
`endif

  assign tc = (phase == PH_LAST);

  always_comb begin
    phase_nxt = phase;
    if (clr)      phase_nxt = '0;
    else if (adv) phase_nxt = tc ? '0 : phase + PH_W'(1);
  end

  always_ff @(posedge x) begin
    if (rst) phase <= '0;
    else     phase <= phase_nxt;
  end

endmodule

// File: rtl/sms_timing_ring.sv
// One-hot timing ring driving gate levels and AC-set pulses to the trigger cards; optional SMS_TIMING_RING_STEP_EN.
// Latency: all outputs registered; gate[0] rises one clock after start is sampled.
// Backpressure: none; stop/single_cycle end the ring only at the end of a full cycle.
module sms_timing_ring
  import sms_timing_pkg::*;
#(
  parameter int POSITIONS    = DEF_POSITIONS,
  parameter int PHASE_CYCLES = DEF_PHASE_CYCLES,
  parameter int PULSE_PHASE  = DEF_PULSE_PHASE
) (
  input  logic                 x,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 single_cycle,
`ifdef SMS_TIMING_RING_STEP_EN
  input  logic                 step,
`endif
  output logic [POSITIONS-1:0] gate,
  output logic [POSITIONS-1:0] gate_n,
  output logic                 ac_set,
  output logic                 cycle_end,
  output logic                 running
);

  localparam int               POS_W    = $clog2(POSITIONS);
  localparam int               PH_W     = $clog2(PHASE_CYCLES);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(POSITIONS - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PHASE_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_PULSE = PH_W'(PULSE_PHASE);

  state_t                 state, state_nxt;
  logic [POS_W-1:0]       pos, pos_nxt;
  logic                   stop_req, stop_req_nxt;
  logic [PH_W-1:0]        phase_nxt;
  logic                   tc, adv;
  logic                   run_nxt, fresh;
  logic [MAX_POSITIONS-1:0] gate_full;
  logic [POSITIONS-1:0]   gate_d;
  logic                   unused_gate_bits;

  sms_timing_phase_ctr #(
    .PHASE_CYCLES (PHASE_CYCLES)
  ) u_phase_ctr (
    .x         (x),
    .rst       (rst),
    .clr       (state == IDLE),
    .en        (state != IDLE),
`ifdef SMS_TIMING_RING_STEP_EN
    .step_mode (single_cycle),
    .step      (step),
`endif
    .phase_nxt (phase_nxt),
    .tc        (tc),
    .adv       (adv)
  );

  always_comb begin
    state_nxt    = state;
    pos_nxt      = pos;
    stop_req_nxt = stop_req;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt    = RUN;
          pos_nxt      = '0;
          stop_req_nxt = stop;
        end
      end
      RUN, STOPPING: begin
        if (stop) stop_req_nxt = 1'b1;
        if (state == RUN && (stop || stop_req)) state_nxt = STOPPING;
        if (adv && tc) begin
          if (pos == POS_LAST) begin
            pos_nxt = '0;
            // A stop seen on the end-of-cycle clock still ends this cycle.
            if (stop_req || stop || single_cycle) begin
              state_nxt    = IDLE;
              stop_req_nxt = 1'b0;
            end
          end else begin
            pos_nxt = pos + POS_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign run_nxt   = (state_nxt != IDLE);
  // Pulses fire only on the clock a phase is entered, not while it is held.
  assign fresh     = (state == IDLE) || adv;
  assign gate_full = onehot_gate(4'(pos_nxt));
  assign gate_d    = gate_full[POSITIONS-1:0];
  assign unused_gate_bits = ^gate_full;

  always_ff @(posedge x) begin
    if (rst) begin
      state     <= IDLE;
      pos       <= '0;
      stop_req  <= 1'b0;
      gate      <= '0;
      gate_n    <= '1;
      ac_set    <= 1'b0;
      cycle_end <= 1'b0;
      running   <= 1'b0;
    end else begin
      state     <= state_nxt;
      pos       <= pos_nxt;
      stop_req  <= stop_req_nxt;
      gate      <= run_nxt ? gate_d : '0;
      gate_n    <= run_nxt ? ~gate_d : '1;
      ac_set    <= run_nxt && fresh && (phase_nxt == PH_PULSE);
      cycle_end <= run_nxt && fresh && (pos_nxt == POS_LAST) && (phase_nxt == PH_LAST);
      running   <= run_nxt;
    end
  end

endmodule

// File: doc/sms_timing_ring.md
Name: sms_timing_ring

Overview:
- Timing ring that produces the gate levels and AC-set pulses consumed by the trigger-binary cards (gate_left/right_*, ac_set_left/right_* inputs).
- A one-hot ring of POSITIONS timing gates, each held for PHASE_CYCLES clocks, with one AC-set pulse per position.
- Start/stop control emulates the machine-cycle run/stop latch.
- Sits directly upstream of the trigger cards on the same clock.

Parameters:
- POSITIONS, 10, number of ring positions (timing gates T0..T(N-1)); legal range 2..16.
- PHASE_CYCLES, 4, clocks per position; legal range 2..16.
- PULSE_PHASE, 2, phase index within a position at which ac_set is asserted; must be < PHASE_CYCLES.

Ports:
- x  input  1  clock; all state updates on posedge x.
- rst  input  1  synchronous active-high reset.
- start  input  1  level; request a run from idle.
- stop  input  1  level; request stop at end of current ring cycle.
- single_cycle  input  1  level; when 1, ring stops after one full cycle.
- gate  output  POSITIONS  one-hot timing gate levels (gate[i] = position i active).
- gate_n  output  POSITIONS  bitwise complement of gate (card-style inverted outputs).
- ac_set  output  1  one-clock pulse per position at PULSE_PHASE.
- cycle_end  output  1  one-clock pulse on the last clock of position POSITIONS-1.
- running  output  1  high in RUN or STOPPING.

Behaviour:
- Interface: one clock, x. Reset is synchronous and active-high, on rst.
- All outputs are registered.
- Reset values: gate=0, gate_n=all 1s, ac_set=0, cycle_end=0, running=0, state=IDLE, pos=0, phase=0, stop_req=0.
- rst overrides every other input, including mid-cycle; the ring is abandoned with no completion pulse.
- States:
  - IDLE: gate=0, no pulses. start=1 -> RUN on the next edge with pos=0 and phase=0, so gate[0]=1 one clock after start is sampled. stop is ignored in IDLE; start and stop together in IDLE -> RUN with stop_req=1.
  - RUN: phase counts 0..PHASE_CYCLES-1.
    - ac_set=1 exactly when phase==PULSE_PHASE.
    - At phase==PHASE_CYCLES-1, pos increments and phase returns to 0.
    - stop=1 sets stop_req; the state moves to STOPPING on the next edge. start is ignored.
  - STOPPING: identical sequencing to RUN; the ring completes the current cycle.
- End of cycle (pos==POSITIONS-1 and phase==PHASE_CYCLES-1):
  - cycle_end=1 for that clock.
  - On the next edge: if stop_req or single_cycle, go to IDLE (gate=0, stop_req cleared, running=0). Otherwise pos wraps to 0 and the ring continues.
- single_cycle is sampled only at the end-of-cycle clock.
- Boundaries:
  - stop arriving on the end-of-cycle clock itself counts for that cycle, so the ring stops immediately.
  - start held high at return to IDLE restarts the ring one clock later; gate is all zero for exactly one clock.
- Exactly one gate bit is high in RUN/STOPPING at all times; gate never changes in the same clock as ac_set.
- Widths: pos is $clog2(POSITIONS) bits and phase is $clog2(PHASE_CYCLES) bits; both wrap explicitly, never by overflow.

Optional Feature:
- Macro: SMS_TIMING_RING_STEP_EN.
- When defined:
  - Adds input step (1 bit).
  - While single_cycle=1 and state is RUN/STOPPING, phase advances only on a rising edge of step, detected by a registered previous value; otherwise phase holds.
  - ac_set and cycle_end fire once per qualifying phase visit, not once per held clock.
- When undefined: no step port; phase advances every clock.

Decomposition:
- Shared package sms_timing_pkg holds:
  - state enum {IDLE, RUN, STOPPING};
  - default constants for POSITIONS, PHASE_CYCLES and PULSE_PHASE;
  - a function that builds the one-hot gate vector from pos.
- One natural sub-module, sms_timing_phase_ctr: the phase counter with enable, terminal-count output and optional step edge detect.

Test Plan:
- Reset then start=1 for 1 clock (defaults): gate=0x001 at clock 1; ac_set at clocks 3, 7, ..., 39; cycle_end at clock 40; gate=0x001 again at clock 41.
- Run, then pulse stop during position 5: ring completes through position 9; cycle_end once; gate=0 and running=0 on the following clock; no further ac_set.
- single_cycle=1 with start pulse: exactly 10 ac_set pulses and 1 cycle_end, then IDLE.
- stop on the end-of-cycle clock: next clock is IDLE. Then start and stop asserted together in IDLE: exactly one cycle runs, then IDLE.
- rst=1 asserted at position 4 phase 2: next clock all outputs at reset values; no cycle_end; the ring stays IDLE until start.
- With SMS_TIMING_RING_STEP_EN and single_cycle=1: step held high for 5 clocks advances phase once; 40 step pulses produce exactly 10 ac_set pulses and 1 cycle_end.
